mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder.
// Sizes, FSM states and request kinds.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    REQ_FETCH,
    REQ_LOAD,
    REQ_STORE
  } req_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between right-aligned core data
// and the 32-bit SRAM word, for both stores and loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] ram_rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] sh;

  always_comb begin
    sh      = ram_rdata_i >> {off_i, 3'b000};
    we_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = sh;
    case (size_i)
      SZ_BYTE: begin
        we_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sgn_i & sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        we_o    = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sgn_i & sh[15]}}, sh[15:0]};
      end
      default: begin
        we_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = sh;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: request check, wait states,
// one SRAM access and a single-cycle ready pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 0,
  localparam int AW         = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cu_fetch,
  input  logic              cu_rd_mem,
  input  logic              cu_wr_mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              ld_signed,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              fault,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS);
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e        state_q, state_d;
  req_e          kind_q, kind_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic          sgn_q, sgn_d;
  logic          fault_q, fault_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    cnt_q, cnt_d;

  req_e        req_kind;
  logic        req_any;
  logic [1:0]  req_size;
  logic        req_bad;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        acc;
  logic        is_st;
  logic        rd_ok;

  mem_lane_align u_align (
    .size_i      (size_q),
    .off_i       (off_q),
    .sgn_i       (sgn_q),
    .wdata_i     (wdata_q),
    .ram_rdata_i (ram_rdata),
    .we_o        (lane_we),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  always_comb begin
    req_any  = cu_wr_mem | cu_rd_mem | cu_fetch;
    req_kind = REQ_FETCH;
    if (cu_wr_mem)      req_kind = REQ_STORE;
    else if (cu_rd_mem) req_kind = REQ_LOAD;
    // Fetch is always a halfword, whatever size says
    req_size = (req_kind == REQ_FETCH) ? SZ_HALF : size;
    req_bad  = (req_size == SZ_RSVD)
             | ((req_size == SZ_HALF) & addr[0])
             | ((req_size == SZ_WORD) & (|addr[1:0]))
             | ({2'b00, addr[ADDR_W-1:2]} >= LIMIT);
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    size_d  = size_q;
    off_d   = off_q;
    sgn_d   = sgn_q;
    fault_d = fault_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          kind_d  = req_kind;
          size_d  = req_size;
          off_d   = addr[1:0];
          sgn_d   = (req_kind == REQ_LOAD) & ld_signed;
          widx_d  = addr[AW+1:2];
          wdata_d = wdata;
          fault_d = req_bad;
          cnt_d   = WLOAD;
          if (req_bad)              state_d = ST_RESP;
          else if (WAIT_CYCLES > 0) state_d = ST_WAIT;
          else                      state_d = ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        if (rd_ok) rdata_d = lane_rdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      kind_q  <= REQ_FETCH;
      size_q  <= SZ_BYTE;
      off_q   <= 2'b00;
      sgn_q   <= 1'b0;
      fault_q <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sgn_q   <= sgn_d;
      fault_q <= fault_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc   = (state_q == ST_ACCESS);
  assign is_st = (kind_q == REQ_STORE);
  assign rd_ok = (state_q == ST_RESP) & ~is_st & ~fault_q;

  assign ram_en    = acc;
  assign ram_we    = (acc & is_st) ? lane_we : 4'b0000;
  assign ram_addr  = acc ? widx_q : '0;
  assign ram_wdata = (acc & is_st) ? lane_wdata : 32'h0;

  // Load data is shown alongside ready and held afterwards
  assign ready = (state_q == ST_RESP);
  assign fault = ready & fault_q;
  assign rdata = rd_ok ? lane_rdata : rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-array model.
// Two instances: no wait states and three wait states.
module tb_mem_responder;

  logic        clk;
  logic        rst_n     [2];
  logic        fetch     [2];
  logic        rd        [2];
  logic        wr        [2];
  logic [31:0] addr      [2];
  logic [1:0]  sz        [2];
  logic        sgn       [2];
  logic [31:0] wdat      [2];
  logic [31:0] rdata     [2];
  logic        ready     [2];
  logic        fault     [2];
  logic        ram_en    [2];
  logic [3:0]  ram_we    [2];
  logic [9:0]  ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];

  logic [31:0] sram [2][1024];
  logic [7:0]  refm [2][4096];
  logic [31:0] last_rd [2];
  int n_chk;
  int n_pass;

  mem_responder #(.ADDR_W(32), .MEM_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst       (rst_n[0]),
    .cu_fetch  (fetch[0]),
    .cu_rd_mem (rd[0]),
    .cu_wr_mem (wr[0]),
    .addr      (addr[0]),
    .size      (sz[0]),
    .ld_signed (sgn[0]),
    .wdata     (wdat[0]),
    .rdata     (rdata[0]),
    .ready     (ready[0]),
    .fault     (fault[0]),
    .ram_en    (ram_en[0]),
    .ram_we    (ram_we[0]),
    .ram_addr  (ram_addr[0]),
    .ram_wdata (ram_wdata[0]),
    .ram_rdata (ram_rdata[0])
  );

  mem_responder #(.ADDR_W(32), .MEM_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
    .clk       (clk),
    .rst       (rst_n[1]),
    .cu_fetch  (fetch[1]),
    .cu_rd_mem (rd[1]),
    .cu_wr_mem (wr[1]),
    .addr      (addr[1]),
    .size      (sz[1]),
    .ld_signed (sgn[1]),
    .wdata     (wdat[1]),
    .rdata     (rdata[1]),
    .ready     (ready[1]),
    .fault     (fault[1]),
    .ram_en    (ram_en[1]),
    .ram_we    (ram_we[1]),
    .ram_addr  (ram_addr[1]),
    .ram_wdata (ram_wdata[1]),
    .ram_rdata (ram_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n[0] && !rst_n[1]) begin
      for (int i = 0; i < 1024; i++) begin
        sram[0][i] <= 32'h0;
        sram[1][i] <= 32'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ram_en[d]) begin
          for (int b = 0; b < 4; b++)
            if (ram_we[d][b])
              sram[d][ram_addr[d]][b*8 +: 8] <= ram_wdata[d][b*8 +: 8];
          ram_rdata[d] <= sram[d][ram_addr[d]];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // kind: 0 fetch, 1 load, 2 store
  function automatic int nbytes(input int k, input logic [1:0] s);
    if (k == 0) return 2;
    return 1 << s;
  endfunction

  function automatic bit exp_fault(input int k, input logic [31:0] a,
                                   input logic [1:0] s);
    int nb;
    if (k != 0 && s == 2'b11) return 1'b1;
    nb = nbytes(k, s);
    if ((int'(a[1:0]) % nb) != 0) return 1'b1;
    if (a[31:2] >= 30'd1024) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input int d, input int k,
      input logic [31:0] a, input logic [1:0] s, input bit sg);
    int nb;
    logic [31:0] v;
    nb = nbytes(k, s);
    v = 32'h0;
    for (int i = 0; i < nb; i++)
      v = v | (32'(refm[d][int'(a[11:0]) + i]) << (8 * i));
    if (k == 1 && sg && nb < 4 && v[8*nb-1])
      v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic model_write(input int d, input logic [31:0] a,
                             input logic [1:0] s, input logic [31:0] wd);
    int nb;
    nb = nbytes(2, s);
    for (int i = 0; i < nb; i++)
      refm[d][int'(a[11:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic xact(input int d, input bit w, input bit r, input bit f,
                      input logic [31:0] a, input logic [1:0] s,
                      input bit sg, input logic [31:0] wd);
    int k, n, lat, en_cnt, en_at, nb;
    bit ef;
    logic [3:0] we_seen, em;
    logic [9:0] ad_seen;
    k  = w ? 2 : (r ? 1 : 0);
    ef = exp_fault(k, a, s);
    lat = ef ? 1 : ((d == 1) ? 5 : 2);
    em = 4'b0000;
    if (k == 2) begin
      nb = nbytes(k, s);
      for (int i = 0; i < nb; i++) em[a[1:0] + 2'(i)] = 1'b1;
    end
    @(negedge clk);
    wr[d] = w; rd[d] = r; fetch[d] = f;
    addr[d] = a; sz[d] = s; sgn[d] = sg; wdat[d] = wd;
    n = 0; en_cnt = 0; en_at = 0; we_seen = 4'h0; ad_seen = 10'h0;
    do begin
      @(posedge clk); #1;
      n++;
      if (ram_en[d]) begin
        en_cnt++;
        en_at = n;
        we_seen = ram_we[d];
        ad_seen = ram_addr[d];
      end
    end while (!ready[d] && n < 40);
    wr[d] = 1'b0; rd[d] = 1'b0; fetch[d] = 1'b0;
    chk("latency", 32'(n), 32'(lat));
    chk("fault", 32'(fault[d]), 32'(ef));
    if (ef) begin
      chk("en_on_fault", 32'(en_cnt), 32'd0);
    end else begin
      chk("en_count", 32'(en_cnt), 32'd1);
      chk("en_cycle", 32'(en_at), 32'(lat - 1));
      chk("ram_we", 32'(we_seen), 32'(em));
      chk("ram_addr", 32'(ad_seen), 32'(a[11:2]));
    end
    if (!ef && k != 2) last_rd[d] = model_read(d, k, a, s, sg);
    chk("rdata", rdata[d], last_rd[d]);
    if (!ef && k == 2) model_write(d, a, s, wd);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(ready[d]), 32'd0);
  endtask

  initial begin
    int en_cnt;
    logic [2:0] rv;
    logic [31:0] a;
    n_chk = 0;
    n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; fetch[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = 32'h0; sz[d] = 2'b00; sgn[d] = 1'b0; wdat[d] = 32'h0;
      last_rd[d] = 32'h0;
      for (int i = 0; i < 4096; i++) refm[d][i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_ready", 32'(ready[d]), 32'h0);
      chk("rst_fault", 32'(fault[d]), 32'h0);
      chk("rst_ram_en", 32'(ram_en[d]), 32'h0);
      chk("rst_ram_we", 32'(ram_we[d]), 32'h0);
      chk("rst_ram_addr", 32'(ram_addr[d]), 32'h0);
      chk("rst_ram_wdata", ram_wdata[d], 32'h0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    xact(0, 1, 0, 0, 32'h10, 2'b10, 0, 32'hDEADBEEF);
    xact(0, 0, 1, 0, 32'h10, 2'b10, 0, 32'h0);
    chk("word_load", rdata[0], 32'hDEADBEEF);
    xact(0, 1, 0, 0, 32'h13, 2'b00, 0, 32'h80);
    xact(0, 0, 1, 0, 32'h13, 2'b00, 1, 32'h0);
    chk("byte_signed", rdata[0], 32'hFFFFFF80);
    xact(0, 0, 1, 0, 32'h13, 2'b00, 0, 32'h0);
    chk("byte_unsigned", rdata[0], 32'h00000080);
    xact(0, 1, 0, 0, 32'h0, 2'b10, 0, 32'h1234ABCD);
    xact(0, 0, 0, 1, 32'h2, 2'b11, 1, 32'h0);
    chk("fetch_hi", rdata[0], 32'h00001234);
    xact(0, 0, 1, 0, 32'h6, 2'b10, 0, 32'h0);
    chk("misalign_keep", rdata[0], 32'h00001234);
    xact(0, 0, 1, 0, 32'd4096, 2'b10, 0, 32'h0);
    chk("oor_keep", rdata[0], 32'h00001234);

    xact(1, 1, 0, 1, 32'h40, 2'b10, 0, 32'h55AA1234);
    xact(1, 0, 0, 1, 32'h40, 2'b00, 0, 32'h0);
    chk("store_won", rdata[1], 32'h00001234);

    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 80; it++) begin
        rv = 3'($urandom_range(1, 7));
        if ($urandom_range(0, 9) == 0) a = $urandom;
        else a = 32'($urandom_range(0, 63));
        xact(d, rv[2], rv[1], rv[0], a, 2'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), $urandom);
      end
    end

    // Reset in the middle of a waiting store
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 32'h20; sz[1] = 2'b10; wdat[1] = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    chk("arst_ready", 32'(ready[1]), 32'h0);
    chk("arst_ram_en", 32'(ram_en[1]), 32'h0);
    chk("arst_ram_we", 32'(ram_we[1]), 32'h0);
    wr[1] = 1'b0;
    en_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ram_en[1]) en_cnt++;
    end
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (ram_en[1]) en_cnt++;
    end
    chk("arst_no_access", 32'(en_cnt), 32'h0);
    last_rd[1] = 32'h0;
    chk("arst_rdata", rdata[1], 32'h0);
    xact(1, 0, 1, 0, 32'h20, 2'b10, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
